// File: rtl/uart_pkg.sv
// Shared UART definitions used by the RX deframer, the TX framer and the SIPO.
//   PAR_EVEN / PAR_ODD : parity-mode encodings driven on the parity_odd inputs.
//   frame_width()      : total bits in one frame (start + data + parity + stop).
package uart_pkg;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    function automatic int frame_width(input int data_w, input int parity_en,
                                       input int stop_bits);
        return 1 + data_w + parity_en + stop_bits;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic single-clock FIFO with wrap-bit pointers.
// Ports:
//   clk, rst   : clock, synchronous active-high reset (empties the queue)
//   i_push     : write request; refused when full unless a pop happens too
//   i_wr_data  : entry to write
//   i_pop      : read request; ignored when empty
//   o_rd_data  : head entry (combinational), zero while empty
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module uart_sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];

    logic w_do_push;
    logic w_do_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    // Same slot index but opposite lap bit: writer is a full lap ahead.
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

    assign w_do_pop  = i_pop & ~o_empty;
    // A pop in the same cycle frees the slot being written when full.
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
    end

    // Storage is not reset, so mask stale contents while empty.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_rx_deframe_fifo.sv
// UART receive deframer: splits a parallel frame into fields, checks parity
// and framing, queues data plus error flags, and keeps status counters.
// Ports:
//   clk, rst                   : clock, synchronous active-high reset
//   frame_parallel, frame_ready: one frame from the SIPO per ready pulse
//   parity_odd                 : 0 even / 1 odd parity
//   data_payload, data_parity_err, data_frame_err, data_valid, data_ready
//                              : head-of-queue entry with valid/ready pop
//   overrun                    : sticky, a frame was dropped on a full queue
//   err_clear                  : clears overrun and all counters
//   parity_err_cnt, frame_err_cnt, overrun_cnt : saturating error counters
module uart_rx_deframe_fifo
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8,
    localparam int FRAME_W   = frame_width(DATA_W, PARITY_EN, STOP_BITS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [FRAME_W-1:0] frame_parallel,
    input  logic               frame_ready,
    input  logic               parity_odd,
    output logic [DATA_W-1:0]  data_payload,
    output logic               data_parity_err,
    output logic               data_frame_err,
    output logic               data_valid,
    input  logic               data_ready,
    output logic               overrun,
    input  logic               err_clear,
    output logic [CNT_W-1:0]   parity_err_cnt,
    output logic [CNT_W-1:0]   frame_err_cnt,
    output logic [CNT_W-1:0]   overrun_cnt
);

    localparam int ENTRY_W = DATA_W + 2;

    // Field slicing. Bit DATA_W+1 is the parity bit when PARITY_EN=1; with no
    // parity it is the first stop bit and the parity result is forced to 0.
    logic                 w_start;
    logic [DATA_W-1:0]    w_data;
    logic                 w_par_bit;
    logic [STOP_BITS-1:0] w_stop;
    logic                 w_parity_err;
    logic                 w_frame_err;

    assign w_start      = frame_parallel[0];
    assign w_data       = frame_parallel[DATA_W:1];
    assign w_par_bit    = frame_parallel[DATA_W+1];
    assign w_stop       = frame_parallel[FRAME_W-1 -: STOP_BITS];
    assign w_parity_err = (PARITY_EN != 0) &&
                          ((^{w_data, w_par_bit}) != (parity_odd == PAR_ODD));
    assign w_frame_err  = w_start | ~(&w_stop);

    // Capture stage
    logic              r_s1_valid;
    logic [DATA_W-1:0] r_s1_data;
    logic              r_s1_perr;
    logic              r_s1_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_perr  <= 1'b0;
            r_s1_ferr  <= 1'b0;
        end else begin
            r_s1_valid <= frame_ready;
            if (frame_ready) begin
                r_s1_data <= w_data;
                r_s1_perr <= w_parity_err;
                r_s1_ferr <= w_frame_err;
            end
        end
    end

    // Enqueue stage
    logic [ENTRY_W-1:0] w_head;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_drop;

    uart_sync_fifo #(
        .WIDTH(ENTRY_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (r_s1_valid),
        .i_wr_data ({r_s1_ferr, r_s1_perr, r_s1_data}),
        .i_pop     (data_ready),
        .o_rd_data (w_head),
        .o_full    (w_full),
        .o_empty   (w_empty)
    );

    assign data_valid      = ~w_empty;
    assign data_payload    = w_head[DATA_W-1:0];
    assign data_parity_err = w_head[DATA_W];
    assign data_frame_err  = w_head[DATA_W+1];

    assign w_pop  = data_valid & data_ready;
    assign w_drop = r_s1_valid & w_full & ~w_pop;

    // Status: err_clear wins over any same-cycle increment or overrun set.
    // Errors on a dropped frame are still counted.
    always_ff @(posedge clk) begin
        if (rst || err_clear) begin
            overrun        <= 1'b0;
            parity_err_cnt <= '0;
            frame_err_cnt  <= '0;
            overrun_cnt    <= '0;
        end else begin
            if (w_drop) overrun <= 1'b1;
            if (r_s1_valid && r_s1_perr && parity_err_cnt != '1)
                parity_err_cnt <= parity_err_cnt + 1'b1;
            if (r_s1_valid && r_s1_ferr && frame_err_cnt != '1)
                frame_err_cnt <= frame_err_cnt + 1'b1;
            if (w_drop && overrun_cnt != '1)
                overrun_cnt <= overrun_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_rx_deframe_fifo.sv
module tb_uart_rx_deframe_fifo;

    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int MAXC  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   frame_parallel;
    logic          frame_ready;
    logic          parity_odd;
    logic [7:0]    data_payload;
    logic          data_parity_err;
    logic          data_frame_err;
    logic          data_valid;
    logic          data_ready;
    logic          overrun;
    logic          err_clear;
    logic [CW-1:0] parity_err_cnt;
    logic [CW-1:0] frame_err_cnt;
    logic [CW-1:0] overrun_cnt;

    uart_rx_deframe_fifo #(
        .DATA_W(8), .PARITY_EN(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .frame_parallel(frame_parallel),
        .frame_ready(frame_ready), .parity_odd(parity_odd),
        .data_payload(data_payload), .data_parity_err(data_parity_err),
        .data_frame_err(data_frame_err), .data_valid(data_valid),
        .data_ready(data_ready), .overrun(overrun), .err_clear(err_clear),
        .parity_err_cnt(parity_err_cnt), .frame_err_cnt(frame_err_cnt),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } ent_t;

    // Reference model: queue of accepted words, one pending captured frame,
    // plain integer counters.
    ent_t q[$];
    bit   pend_v;
    ent_t pend;
    int   m_pc, m_fc, m_oc;
    bit   m_ov;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a frame with correct parity for the given mode, optionally corrupted.
    function automatic logic [10:0] mk(input logic [7:0] d, input bit bad_par,
                                       input bit start, input bit stop, input bit odd);
        bit pbit;
        pbit = bit'($countones(d) % 2) ^ odd ^ bad_par;
        return {stop, pbit, d, start};
    endfunction

    function automatic ent_t decode(input logic [10:0] f, input bit odd);
        ent_t e;
        e.d  = f[8:1];
        e.pe = ((($countones(e.d) + int'(f[9])) % 2) != int'(odd));
        e.fe = (f[0] == 1'b1) || (f[10] == 1'b0);
        return e;
    endfunction

    function automatic int sat(input int v);
        return (v < MAXC) ? v + 1 : v;
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".valid"}, 32'(data_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk({tag, ".data"}, 32'(data_payload), 32'(q[0].d));
            chk({tag, ".perr"}, 32'(data_parity_err), 32'(q[0].pe));
            chk({tag, ".ferr"}, 32'(data_frame_err), 32'(q[0].fe));
        end
        chk({tag, ".overrun"}, 32'(overrun), 32'(m_ov));
        chk({tag, ".pcnt"}, 32'(parity_err_cnt), 32'(m_pc));
        chk({tag, ".fcnt"}, 32'(frame_err_cnt), 32'(m_fc));
        chk({tag, ".ocnt"}, 32'(overrun_cnt), 32'(m_oc));
    endtask

    // One clock: drive inputs, advance the model across the edge, compare.
    task automatic step(input string tag, input bit fr, input logic [10:0] f,
                        input bit dr, input bit clr, input bit rs);
        bit pop, drop;
        frame_ready    = fr;
        frame_parallel = f;
        data_ready     = dr;
        err_clear      = clr;
        rst            = rs;
        if (rs) begin
            q.delete();
            pend_v = 0;
            m_pc = 0; m_fc = 0; m_oc = 0; m_ov = 0;
        end else begin
            pop  = dr && (q.size() > 0);
            drop = pend_v && (q.size() == DEPTH) && !pop;
            if (clr) begin
                m_pc = 0; m_fc = 0; m_oc = 0; m_ov = 0;
            end else begin
                if (pend_v && pend.pe) m_pc = sat(m_pc);
                if (pend_v && pend.fe) m_fc = sat(m_fc);
                if (drop) begin
                    m_ov = 1;
                    m_oc = sat(m_oc);
                end
            end
            if (pop) void'(q.pop_front());
            if (pend_v && !drop) q.push_back(pend);
            pend_v = fr;
            if (fr) pend = decode(f, parity_odd);
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, ".valid0"}, 32'(data_valid), 0);
        chk({tag, ".data0"}, 32'(data_payload), 0);
        chk({tag, ".perr0"}, 32'(data_parity_err), 0);
        chk({tag, ".ferr0"}, 32'(data_frame_err), 0);
        chk({tag, ".ov0"}, 32'(overrun), 0);
        chk({tag, ".cnt0"}, 32'({parity_err_cnt, frame_err_cnt, overrun_cnt}), 0);
    endtask

    initial begin
        logic [10:0] rf;
        frame_parallel = '0; frame_ready = 0; parity_odd = 0;
        data_ready = 0; err_clear = 0; rst = 1;
        pend_v = 0; m_pc = 0; m_fc = 0; m_oc = 0; m_ov = 0;

        // Reset
        step("rst", 0, '0, 0, 0, 1);
        step("rst", 0, '0, 0, 0, 1);
        check_reset_outputs("rst");

        // 1. Clean frame: valid exactly one cycle, two edges after the pulse
        step("t1a", 1, 11'h54A, 1, 0, 0);
        chk("t1.lat1", 32'(data_valid), 0);
        step("t1b", 0, '0, 1, 0, 0);
        chk("t1.valid", 32'(data_valid), 1);
        chk("t1.data", 32'(data_payload), 32'hA5);
        step("t1c", 0, '0, 1, 0, 0);
        chk("t1.gone", 32'(data_valid), 0);

        // 2. Error frames
        step("t2a", 1, 11'h74A, 1, 0, 0);
        step("t2a", 0, '0, 1, 0, 0);
        chk("t2.perr", 32'(data_parity_err), 1);
        step("t2b", 1, 11'h54B, 1, 0, 0);
        step("t2b", 0, '0, 1, 0, 0);
        chk("t2.ferr_start", 32'(data_frame_err), 1);
        step("t2c", 1, 11'h14A, 1, 0, 0);
        step("t2c", 0, '0, 1, 0, 0);
        chk("t2.ferr_stop", 32'(data_frame_err), 1);
        step("t2c", 0, '0, 1, 0, 0);
        chk("t2.pcnt", 32'(parity_err_cnt), 1);
        chk("t2.fcnt", 32'(frame_err_cnt), 2);
        parity_odd = 1;
        step("t2d", 1, 11'h74A, 1, 0, 0);
        step("t2d", 0, '0, 1, 0, 0);
        chk("t2.odd_ok", 32'({data_parity_err, data_frame_err}), 0);
        step("t2d", 0, '0, 1, 0, 0);
        parity_odd = 0;

        // 3. Overrun: five back-to-back frames into a 4-deep queue
        for (int i = 1; i <= 5; i++) step("t3fill", 1, mk(8'(i), 0, 0, 1, 0), 0, 0, 0);
        step("t3idle", 0, '0, 0, 0, 0);
        chk("t3.ov", 32'(overrun), 1);
        chk("t3.ocnt", 32'(overrun_cnt), 1);
        step("t3hold", 0, '0, 0, 0, 0);
        chk("t3.hold", 32'(data_payload), 1);
        for (int i = 1; i <= 4; i++) begin
            chk("t3.drain", 32'(data_payload), 32'(i));
            step("t3drain", 0, '0, 1, 0, 0);
        end
        chk("t3.empty", 32'(data_valid), 0);
        step("t3empty_rdy", 0, '0, 1, 0, 0);

        // 4. Full queue with simultaneous push and pop
        step("t4clr", 0, '0, 0, 1, 0);
        for (int i = 6; i <= 9; i++) step("t4fill", 1, mk(8'(i), 0, 0, 1, 0), 0, 0, 0);
        step("t4new", 1, mk(8'h0A, 0, 0, 1, 0), 0, 0, 0);
        step("t4pp", 0, '0, 1, 0, 0);
        chk("t4.no_ov", 32'(overrun), 0);
        for (int i = 7; i <= 10; i++) begin
            chk("t4.order", 32'(data_payload), 32'(i));
            step("t4drain", 0, '0, 1, 0, 0);
        end

        // 5. Saturation and clear priority
        step("t5clr", 0, '0, 1, 1, 0);
        for (int i = 0; i < 5; i++) step("t5err", 1, mk(8'(i * 37), 1, 0, 1, 0), 1, 0, 0);
        step("t5idle", 0, '0, 1, 0, 0);
        chk("t5.sat", 32'(parity_err_cnt), 3);
        step("t5six", 1, mk(8'h33, 1, 1, 0, 0), 1, 0, 0);
        step("t5clr6", 0, '0, 1, 1, 0);
        chk("t5.clr_p", 32'(parity_err_cnt), 0);
        chk("t5.clr_f", 32'(frame_err_cnt), 0);
        chk("t5.clr_ov", 32'(overrun), 0);
        step("t5idle", 0, '0, 1, 0, 0);

        // 6. Reset mid-operation: 3 queued plus one in capture
        for (int i = 0; i < 4; i++) step("t6fill", 1, mk(8'(8'hC0 + i), 0, 0, 1, 0), 0, 0, 0);
        chk("t6.queued", 32'(data_valid), 1);
        step("t6rst", 0, '0, 0, 0, 1);
        check_reset_outputs("t6");
        for (int i = 0; i < 3; i++) step("t6after", 0, '0, 1, 0, 0);
        chk("t6.no_replay", 32'(data_valid), 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            rf = 11'($urandom());
            parity_odd = 1'($urandom_range(0, 1));
            step("rand", ($urandom_range(0, 99) < 55), rf, ($urandom_range(0, 99) < 45),
                 ($urandom_range(0, 29) == 0), 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
